// File: rtl/nibble_cnt_pkg.sv
// Shared constants for the nibble address counter.
//   NIB_W          : width of one counter cell (a nibble)
//   SAT_WRAP/HOLD  : values for the SATURATE parameter
//   CE_LAT_DIRECT/REG : legal values for the CE_LAT parameter
//   at_bound()     : true when a nibble sits at the count boundary for the direction
package nibble_cnt_pkg;
  localparam int NIB_W         = 4;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_HOLD      = 1;
  localparam int CE_LAT_DIRECT = 0;
  localparam int CE_LAT_REG    = 1;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  // Up counts roll over from all-ones, down counts borrow from zero.
  function automatic logic at_bound(input logic [NIB_W-1:0] v, input logic up);
    return up ? (&v) : ~(|v);
  endfunction
endpackage

// File: rtl/nibble_addr_counter_if.sv
// Control/data bundle of the nibble address counter.
//   master : drives CE, UP, ALE, D; observes Q, TC, OVF
//   slave  : the counter side
interface nibble_addr_counter_if
  import nibble_cnt_pkg::*;
#(
  parameter int NIB = 4
);
  logic                 CE;
  logic                 UP;
  logic [NIB-1:0]       ALE;
  logic [NIB_W-1:0]     D;
  logic [NIB*NIB_W-1:0] Q;
  logic                 TC;
  logic                 OVF;

  modport master (output CE, UP, ALE, D, input  Q, TC, OVF);
  modport slave  (input  CE, UP, ALE, D, output Q, TC, OVF);
endinterface

// File: rtl/nibble_cnt_cell.sv
// One 4-bit slice of the ripple-chained counter.
//   CLK, CLR_N : clock, synchronous active-low clear
//   ld, d      : load strobe and nibble data (load beats counting)
//   en         : global count permission (no load anywhere, not saturated)
//   up         : direction, 1 = increment
//   cin        : carry/borrow in; chain head is the effective enable
//   q          : nibble value
//   cout       : cin AND nibble at its boundary for the direction
module nibble_cnt_cell
  import nibble_cnt_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             ld,
  input  logic [NIB_W-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             cin,
  output logic [NIB_W-1:0] q,
  output logic             cout
);
  assign cout = cin & at_bound(q, up);

  always_ff @(posedge CLK) begin
    if (!CLR_N)        q <= '0;
    else if (ld)       q <= d;
    else if (en & cin) q <= up ? q + 1'b1 : q - 1'b1;
  end
endmodule

// File: rtl/nibble_addr_counter.sv
// Loadable up/down address counter built from NIB ripple-chained nibble cells.
//   CLK      : clock, rising edge
//   CLR_N    : synchronous active-low clear (Q, OVF, CE pipeline)
//   bus.CE   : count enable (optionally delayed one cycle, CE_LAT)
//   bus.UP   : direction, 1 = up
//   bus.ALE  : per-nibble load strobes, load D into every selected nibble
//   bus.D    : shared nibble load data
//   bus.Q    : counter value
//   bus.TC   : combinational terminal count (top cell carry-out)
//   bus.OVF  : one-cycle pulse after a boundary-crossing count
module nibble_addr_counter
  import nibble_cnt_pkg::*;
#(
  parameter int NIB      = 4,
  parameter int CE_LAT   = CE_LAT_REG,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  nibble_addr_counter_if.slave  bus
);
  logic                 ce_sel, ce_eff, ld_any, sat_block, cnt_en, ovf_r;
  logic [NIB:0]         carry;
  logic [NIB*NIB_W-1:0] q_all;

  if (CE_LAT == CE_LAT_REG) begin : g_ce_reg
    logic ce_q;
    always_ff @(posedge CLK) begin
      if (!CLR_N) ce_q <= 1'b0;
      else        ce_q <= bus.CE;
    end
    assign ce_sel = ce_q;
  end else begin : g_ce_dir
    assign ce_sel = bus.CE;
  end

  // Masked by CLR_N so TC stays low while clear is asserted.
  assign ce_eff    = CLR_N & ce_sel;
  assign carry[0]  = ce_eff;
  assign ld_any    = |bus.ALE;
  // In hold mode a count at the boundary is swallowed; OVF still pulses.
  assign sat_block = (SATURATE == SAT_HOLD) ? carry[NIB] : 1'b0;
  assign cnt_en    = ~ld_any & ~sat_block;

  for (genvar i = 0; i < NIB; i++) begin : g_cell
    nibble_cnt_cell u_cell (
      .CLK  (CLK),
      .CLR_N(CLR_N),
      .ld   (bus.ALE[i]),
      .d    (bus.D),
      .en   (cnt_en),
      .up   (bus.UP),
      .cin  (carry[i]),
      .q    (q_all[i*NIB_W +: NIB_W]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) ovf_r <= 1'b0;
    else        ovf_r <= carry[NIB] & ~ld_any;
  end

  assign bus.Q   = q_all;
  assign bus.TC  = carry[NIB];
  assign bus.OVF = ovf_r;
endmodule

// File: tb/tb_nibble_addr_counter.sv
module tb_nibble_addr_counter;
  import nibble_cnt_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic clr0, clr1, clr2;

  nibble_addr_counter_if #(.NIB(4)) bus0 ();
  nibble_addr_counter_if #(.NIB(4)) bus1 ();
  nibble_addr_counter_if #(.NIB(4)) bus2 ();

  // 0: registered CE, wrap   1: registered CE, saturate   2: direct CE, wrap
  nibble_addr_counter #(.NIB(4), .CE_LAT(1), .SATURATE(0)) dut0 (.CLK(CLK), .CLR_N(clr0), .bus(bus0));
  nibble_addr_counter #(.NIB(4), .CE_LAT(1), .SATURATE(1)) dut1 (.CLK(CLK), .CLR_N(clr1), .bus(bus1));
  nibble_addr_counter #(.NIB(4), .CE_LAT(0), .SATURATE(0)) dut2 (.CLK(CLK), .CLR_N(clr2), .bus(bus2));

  typedef struct {
    int          dut;
    string       name;
    logic [15:0] q;
    logic        tc;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // One cycle: apply inputs, queue what the DUT must show before the next
  // edge (Q/OVF from the previous edge, TC from these inputs), then step.
  task automatic cyc(input int dut, input logic chk, input logic clr, input logic ce,
                     input logic up, input logic [3:0] ale, input logic [3:0] d,
                     input string name, input logic [15:0] eq, input logic etc,
                     input logic eovf);
    exp_t e;
    case (dut)
      0: begin clr0 = clr; bus0.CE = ce; bus0.UP = up; bus0.ALE = ale; bus0.D = d; end
      1: begin clr1 = clr; bus1.CE = ce; bus1.UP = up; bus1.ALE = ale; bus1.D = d; end
      default: begin clr2 = clr; bus2.CE = ce; bus2.UP = up; bus2.ALE = ale; bus2.D = d; end
    endcase
    if (chk) begin
      e.dut = dut; e.name = name; e.q = eq; e.tc = etc; e.ovf = eovf;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard on the falling edge, away from updates.
  always @(negedge CLK) begin
    exp_t        e;
    logic [15:0] aq;
    logic        atc, aovf;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin aq = bus0.Q; atc = bus0.TC; aovf = bus0.OVF; end
        1: begin aq = bus1.Q; atc = bus1.TC; aovf = bus1.OVF; end
        default: begin aq = bus2.Q; atc = bus2.TC; aovf = bus2.OVF; end
      endcase
      cmp(e.name, "Q",   aq,            e.q);
      cmp(e.name, "TC",  {15'd0, atc},  {15'd0, e.tc});
      cmp(e.name, "OVF", {15'd0, aovf}, {15'd0, e.ovf});
    end
  end

  initial begin
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    bus0.CE = 1'b0; bus0.UP = 1'b1; bus0.ALE = '0; bus0.D = '0;
    bus1.CE = 1'b0; bus1.UP = 1'b1; bus1.ALE = '0; bus1.D = '0;
    bus2.CE = 1'b0; bus2.UP = 1'b1; bus2.ALE = '0; bus2.D = '0;

    // ---- dut0: CE_LAT=1, wrap ----
    //  dut chk clr ce up ale      d     name            Q        TC   OVF
    cyc(0, 0, 0, 1, 1, 4'b0000, 4'h0, "",              16'h0000, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0000, 4'h0, "reset",         16'h0000, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0000, 4'h0, "cnt_e1",        16'h0000, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0000, 4'h0, "cnt_e2",        16'h0001, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b1000, 4'h1, "cnt_e3",        16'h0002, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0100, 4'h2, "ld_n3",         16'h1002, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0010, 4'h3, "ld_n2",         16'h1202, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0001, 4'h4, "ld_n1",         16'h1232, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0101, 4'hA, "ld_1234",       16'h1234, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "ld_multi",      16'h1A3A, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "cnt_after_ld",  16'h1A3B, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b1111, 4'hF, "hold_ce0",      16'h1A3B, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "wrap_tc",       16'hFFFF, 1, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "wrap_ovf",      16'h0000, 0, 1);
    cyc(0, 1, 1, 1, 0, 4'b0000, 4'h0, "ovf_one_cyc",   16'h0000, 0, 0);
    cyc(0, 1, 1, 0, 0, 4'b0000, 4'h0, "dn_tc",         16'h0000, 1, 0);
    cyc(0, 1, 1, 0, 0, 4'b0000, 4'h0, "dn_wrap",       16'hFFFF, 0, 1);
    cyc(0, 1, 1, 0, 1, 4'b1111, 4'h0, "dn_ovf_clr",    16'hFFFF, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0011, 4'hF, "ld_zero",       16'h0000, 0, 0);
    cyc(0, 1, 1, 1, 1, 4'b0001, 4'hE, "ld_00ff",       16'h00FF, 0, 0);
    cyc(0, 1, 0, 1, 1, 4'b1111, 4'h5, "pre_clr",       16'h00FE, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "clr_mid",       16'h0000, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b0000, 4'h0, "clr_no_pend",   16'h0000, 0, 0);

    // ---- dut1: CE_LAT=1, saturate ----
    cyc(1, 0, 0, 0, 0, 4'b0000, 4'h0, "",              16'h0000, 0, 0);
    cyc(1, 1, 1, 1, 0, 4'b0000, 4'h0, "s_reset",       16'h0000, 0, 0);
    cyc(1, 1, 1, 0, 0, 4'b0000, 4'h0, "s_dn_tc",       16'h0000, 1, 0);
    cyc(1, 1, 1, 0, 0, 4'b0000, 4'h0, "s_dn_hold",     16'h0000, 0, 1);
    cyc(1, 1, 1, 1, 1, 4'b1111, 4'hF, "s_ovf_1cyc",    16'h0000, 0, 0);
    cyc(1, 1, 1, 1, 1, 4'b0000, 4'h0, "s_up_tc",       16'hFFFF, 1, 0);
    cyc(1, 1, 1, 0, 1, 4'b0000, 4'h0, "s_up_hold",     16'hFFFF, 1, 1);
    cyc(1, 1, 1, 0, 0, 4'b0000, 4'h0, "s_up_hold2",    16'hFFFF, 0, 1);
    cyc(1, 1, 1, 0, 0, 4'b0000, 4'h0, "s_ovf_end",     16'hFFFF, 0, 0);

    // ---- dut2: CE_LAT=0, wrap ----
    cyc(2, 0, 0, 1, 1, 4'b0000, 4'h0, "",              16'h0000, 0, 0);
    cyc(2, 1, 0, 1, 1, 4'b1111, 4'h5, "d_rst_tc",      16'h0000, 0, 0);
    cyc(2, 1, 1, 1, 1, 4'b0010, 4'h1, "d_reset",       16'h0000, 0, 0);
    cyc(2, 1, 1, 1, 1, 4'b0000, 4'h0, "d_ld_0010",     16'h0010, 0, 0);
    cyc(2, 1, 1, 1, 0, 4'b0000, 4'h0, "d_up",          16'h0011, 0, 0);
    cyc(2, 1, 1, 1, 1, 4'b0000, 4'h0, "d_dn",          16'h0010, 0, 0);
    cyc(2, 1, 1, 0, 1, 4'b0000, 4'h0, "d_up2",         16'h0011, 0, 0);
    cyc(2, 1, 1, 0, 1, 4'b1111, 4'h0, "d_hold",        16'h0011, 0, 0);
    cyc(2, 1, 1, 1, 0, 4'b0001, 4'h0, "d_tc_with_ale", 16'h0000, 1, 0);
    cyc(2, 1, 1, 1, 0, 4'b0000, 4'h0, "d_ld_no_ovf",   16'h0000, 1, 0);
    cyc(2, 1, 1, 0, 0, 4'b0000, 4'h0, "d_dn_wrap",     16'hFFFF, 0, 1);

    // Scoreboard must drain within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_addr_counter.md
NIBBLE_ADDR_COUNTER -- requirements
Module: nibble_addr_counter

Interface
REQ-001 The block SHALL have parameter NIB, default 4, setting the number of 4-bit nibbles (range 1..8).
REQ-002 The block SHALL have parameter CE_LAT, default 1, setting count-enable latency: 0 = CE used directly, 1 = CE registered one cycle.
REQ-003 The block SHALL have parameter SATURATE, default 0, selecting boundary behaviour: 0 = wrap, 1 = hold at the boundary.
REQ-004 The block SHALL have a clock CLK, input, 1 bit, on which all state updates occur at the rising edge.
REQ-005 The block SHALL have a reset CLR_N, input, 1 bit, which is synchronous and active-low.
REQ-006 The block SHALL have CE, input, 1 bit, count enable, active-high.
REQ-007 The block SHALL have UP, input, 1 bit, count direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have ALE, input, NIB bits, per-nibble load strobes.
REQ-009 The block SHALL have D, input, 4 bits, shared nibble load data.
REQ-010 The block SHALL have Q, output, 4*NIB bits, the registered counter value.
REQ-011 The block SHALL have TC, output, 1 bit, combinational terminal count.
REQ-012 The block SHALL have OVF, output, 1 bit, registered one-cycle boundary-crossing pulse.

Function
REQ-013 The effective enable ce_eff SHALL be CE when CE_LAT=0, and CE sampled at the previous edge when CE_LAT=1.
REQ-014 When ALE[i]=1, Q[4i+3:4i] SHALL take D at the edge; several set ALE bits SHALL load D into every selected nibble.
REQ-015 In any cycle with ALE nonzero, unselected nibbles SHALL hold and no count SHALL occur; load has priority over ce_eff.
REQ-016 With ALE=0 and ce_eff=1, Q SHALL become Q+1 when UP=1 and Q-1 when UP=0, modulo 2^(4*NIB).
REQ-017 With ALE=0 and ce_eff=0, Q SHALL hold.
REQ-018 TC SHALL be ce_eff AND (Q=all-ones when UP=1, or Q=0 when UP=0), independent of ALE.
REQ-019 With SATURATE=0, a count from all-ones up SHALL give 0, and a count from 0 down SHALL give all-ones.
REQ-020 With SATURATE=1, a count at the boundary (TC=1, ALE=0) SHALL leave Q unchanged.
REQ-021 OVF SHALL be 1 for exactly the cycle after an edge at which TC=1 and ALE=0 (either SATURATE setting), and 0 otherwise.
REQ-022 A change of UP SHALL take effect on the same edge it is sampled; a registered CE SHALL apply with the UP value current at the counting edge.
REQ-023 Count latency SHALL be 1 edge from CE for CE_LAT=0 and 2 edges for CE_LAT=1; load latency SHALL be 1 edge.

Reset
REQ-024 When CLR_N=0 at an edge, the block SHALL set Q=0, OVF=0 and the CE pipeline register to 0, overriding ALE and CE.
REQ-025 After reset release, the first count SHALL need CE high for CE_LAT+1 edges; no pre-reset CE SHALL be retained.
REQ-026 TC SHALL read 0 during and after reset until ce_eff is 1.

Structure
REQ-027 Shared package nibble_cnt_pkg SHALL hold NIB_W=4, the SATURATE mode constants and the CE_LAT legal values.
REQ-028 One sub-module, nibble_cnt_cell, SHALL be instantiated NIB times as a 4-bit cell with load, enable, direction and carry/borrow-out, chained ripple-style.
REQ-029 Carry-out of cell i SHALL be ce_eff AND (cell i at its boundary for the direction) AND carry-in of cell i, and TC SHALL equal the carry-out of the top cell.

Verification
REQ-030 The bench SHALL check, with NIB=4 and CE_LAT=1: reset, then CE=1 held for 3 edges -> Q=0x0000 after the first edge, then 0x0001, then 0x0002.
REQ-031 The bench SHALL check: ALE=4'b0101 with D=0xA while CE=1 at Q=0x1234 -> Q=0x1A3A, with no increment that cycle.
REQ-032 The bench SHALL check, with SATURATE=0 and UP=1: Q=0xFFFF with ce_eff=1 -> TC=1, next Q=0x0000 and OVF=1 for one cycle.
REQ-033 The bench SHALL check, with SATURATE=1 and UP=0: Q=0x0000 with ce_eff=1 -> TC=1, Q stays 0x0000 and OVF=1 for one cycle.
REQ-034 The bench SHALL check: CLR_N=0 for one edge mid-count at Q=0x00FE with ALE=4'b1111 -> Q=0x0000, OVF=0, and the pending count is dropped.
REQ-035 The bench SHALL check, with CE_LAT=0, UP toggling each cycle from Q=0x0010 -> Q runs 0x0011, 0x0010, 0x0011.
